// File: rtl/vip_ycbcr444_rgb888.sv
// vip_ycbcr444_rgb888: full-range BT.601 YCbCr444 -> RGB888, 3-stage pipeline,
// one pixel per clk, with vsync/href/clken delayed to stay aligned to the data.
// Optional build macro VIP_YCBCR_SAT_CNT_EN adds a per-frame count of clamped pixels.
`timescale 1ns/1ps

module vip_ycbcr444_rgb888 #(
    parameter int unsigned SAT_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 per_frame_vsync,
    input  logic                 per_frame_href,
    input  logic                 per_frame_clken,
    input  logic [7:0]           per_img_Y,
    input  logic [7:0]           per_img_Cb,
    input  logic [7:0]           per_img_Cr,
    output logic                 post_frame_vsync,
    output logic                 post_frame_href,
    output logic                 post_frame_clken,
    output logic [7:0]           post_img_red,
    output logic [7:0]           post_img_green,
    output logic [7:0]           post_img_blue
`ifdef VIP_YCBCR_SAT_CNT_EN
    ,
    output logic [SAT_CNT_W-1:0] sat_count
`endif
);

    localparam int unsigned PIX_W  = 8;
    localparam int unsigned PROD_W = 20;
    localparam int unsigned DLY    = 3;

    // Chroma with the 128 offset removed
    logic signed [8:0]        cbd_c;
    logic signed [8:0]        crd_c;

    // Stage 1: scaled luma and chroma products
    logic signed [PROD_W-1:0] y256_q;
    logic signed [PROD_W-1:0] r_cr_q;
    logic signed [PROD_W-1:0] g_cb_q;
    logic signed [PROD_W-1:0] g_cr_q;
    logic signed [PROD_W-1:0] b_cb_q;

    // Stage 2: rounded x256 channel sums
    logic signed [PROD_W-1:0] r_sum_q;
    logic signed [PROD_W-1:0] g_sum_q;
    logic signed [PROD_W-1:0] b_sum_q;

    // Sync delay lines; bit DLY-1 is the output
    logic [DLY-1:0]           vsync_d;
    logic [DLY-1:0]           href_d;
    logic [DLY-1:0]           clken_d;

    assign cbd_c = $signed({1'b0, per_img_Cb}) - 9'sd128;
    assign crd_c = $signed({1'b0, per_img_Cr}) - 9'sd128;

    assign post_frame_vsync = vsync_d[DLY-1];
    assign post_frame_href  = href_d[DLY-1];
    assign post_frame_clken = clken_d[DLY-1];

    // Drop the x256 scaling (floor) and clamp to 0..255
    function automatic logic [PIX_W-1:0] clamp8(input logic signed [PROD_W-1:0] v);
        logic signed [PROD_W-1:0] sh;
        sh = v >>> 8;
        if (sh[PROD_W-1])
            clamp8 = '0;
        else if (sh > PROD_W'(255))
            clamp8 = '1;
        else
            clamp8 = sh[PIX_W-1:0];
    endfunction

    // Stage 1: multiply chroma differences by the fixed x256 coefficients
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y256_q <= '0;
            r_cr_q <= '0;
            g_cb_q <= '0;
            g_cr_q <= '0;
            b_cb_q <= '0;
        end else begin
            y256_q <= $signed({4'd0, per_img_Y, 8'd0});
            r_cr_q <= PROD_W'(crd_c) * 20'sd359;
            g_cb_q <= PROD_W'(cbd_c) * 20'sd88;
            g_cr_q <= PROD_W'(crd_c) * 20'sd183;
            b_cb_q <= PROD_W'(cbd_c) * 20'sd454;
        end
    end

    // Stage 2: channel sums with +128 for round-to-nearest
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sum_q <= '0;
            g_sum_q <= '0;
            b_sum_q <= '0;
        end else begin
            r_sum_q <= y256_q + r_cr_q + 20'sd128;
            g_sum_q <= y256_q - g_cb_q - g_cr_q + 20'sd128;
            b_sum_q <= y256_q + b_cb_q + 20'sd128;
        end
    end

    // Stage 3: scale down, clamp, and blank outside href (href_d[1] lands in the output with this data)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            post_img_red   <= '0;
            post_img_green <= '0;
            post_img_blue  <= '0;
        end else if (href_d[DLY-2]) begin
            post_img_red   <= clamp8(r_sum_q);
            post_img_green <= clamp8(g_sum_q);
            post_img_blue  <= clamp8(b_sum_q);
        end else begin
            post_img_red   <= '0;
            post_img_green <= '0;
            post_img_blue  <= '0;
        end
    end

    // Sync shift registers matching the 3-stage data latency
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vsync_d <= '0;
            href_d  <= '0;
            clken_d <= '0;
        end else begin
            vsync_d <= {vsync_d[DLY-2:0], per_frame_vsync};
            href_d  <= {href_d[DLY-2:0],  per_frame_href};
            clken_d <= {clken_d[DLY-2:0], per_frame_clken};
        end
    end

`ifdef VIP_YCBCR_SAT_CNT_EN
    // True when the pre-clamp value falls outside 0..255
    function automatic logic clamped(input logic signed [PROD_W-1:0] v);
        logic signed [PROD_W-1:0] sh;
        sh = v >>> 8;
        clamped = sh[PROD_W-1] | (sh > PROD_W'(255));
    endfunction

    logic                 sat_flag_q;
    logic                 vsync_prev_q;
    logic [SAT_CNT_W-1:0] sat_cnt_q;
    logic                 sat_inc_c;
    logic                 vsync_rise_c;

    assign sat_inc_c    = sat_flag_q & clken_d[DLY-1] & href_d[DLY-1];
    assign vsync_rise_c = vsync_d[DLY-1] & ~vsync_prev_q;

    // Clamp flag travels with the stage-3 pixel it belongs to
    always_ff @(posedge clk) begin
        if (!rst_n)
            sat_flag_q <= 1'b0;
        else
            sat_flag_q <= clamped(r_sum_q) | clamped(g_sum_q) | clamped(b_sum_q);
    end

    // Per-frame saturating count, published and restarted on delayed vsync rise
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vsync_prev_q <= 1'b0;
            sat_cnt_q    <= '0;
            sat_count    <= '0;
        end else begin
            vsync_prev_q <= vsync_d[DLY-1];
            if (vsync_rise_c) begin
                sat_count <= sat_cnt_q;
                sat_cnt_q <= sat_inc_c ? SAT_CNT_W'(1) : '0;
            end else if (sat_inc_c && (sat_cnt_q != '1)) begin
                sat_cnt_q <= sat_cnt_q + SAT_CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_vip_ycbcr444_rgb888.sv
// Directed self-checking bench for vip_ycbcr444_rgb888.
`timescale 1ns/1ps

module tb_vip_ycbcr444_rgb888;

    localparam int unsigned TB_SAT_W = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       per_frame_vsync = 1'b0;
    logic       per_frame_href = 1'b0;
    logic       per_frame_clken = 1'b0;
    logic [7:0] per_img_Y = 8'd0;
    logic [7:0] per_img_Cb = 8'd128;
    logic [7:0] per_img_Cr = 8'd128;
    logic       post_frame_vsync;
    logic       post_frame_href;
    logic       post_frame_clken;
    logic [7:0] post_img_red;
    logic [7:0] post_img_green;
    logic [7:0] post_img_blue;
`ifdef VIP_YCBCR_SAT_CNT_EN
    logic [TB_SAT_W-1:0] sat_count;
`endif

    int checks = 0;
    int errors = 0;

    vip_ycbcr444_rgb888 #(.SAT_CNT_W(TB_SAT_W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .per_frame_vsync  (per_frame_vsync),
        .per_frame_href   (per_frame_href),
        .per_frame_clken  (per_frame_clken),
        .per_img_Y        (per_img_Y),
        .per_img_Cb       (per_img_Cb),
        .per_img_Cr       (per_img_Cr),
        .post_frame_vsync (post_frame_vsync),
        .post_frame_href  (post_frame_href),
        .post_frame_clken (post_frame_clken),
        .post_img_red     (post_img_red),
        .post_img_green   (post_img_green),
        .post_img_blue    (post_img_blue)
`ifdef VIP_YCBCR_SAT_CNT_EN
        ,
        .sat_count        (sat_count)
`endif
    );

    always #5 clk = ~clk;

    // Sync alignment table: vsync 2 clk, href 4 clk, clken alternating; idle Y=77 must be blanked
    int sa_v [10] = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    int sa_h [10] = '{0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
    int sa_c [10] = '{0, 0, 1, 0, 1, 0, 0, 0, 0, 0};
    int sa_y [10] = '{77, 77, 10, 20, 30, 40, 77, 77, 77, 77};
    int sa_e [10] = '{0, 0, 10, 20, 30, 40, 0, 0, 0, 0};

    // Back-to-back table with hand-computed RGB
    int bb_y  [4] = '{100, 200, 50, 30};
    int bb_cb [4] = '{150, 60, 100, 10};
    int bb_cr [4] = '{100, 180, 140, 128};
    int bb_r  [4] = '{61, 255, 67, 30};
    int bb_g  [4] = '{112, 186, 51, 71};
    int bb_b  [4] = '{139, 79, 0, 0};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic h, input logic c,
                         input logic [7:0] y, input logic [7:0] cb, input logic [7:0] cr);
        per_frame_vsync = v;
        per_frame_href  = h;
        per_frame_clken = c;
        per_img_Y       = y;
        per_img_Cb      = cb;
        per_img_Cr      = cr;
    endtask

    task automatic idle;
        drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd128, 8'd128);
    endtask

    task automatic flush;
        idle();
        repeat (4) tick();
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 8'd200, 8'd30, 8'd220);
        tick();
        tick();
        checks++;
        if ({post_frame_vsync, post_frame_href, post_frame_clken} !== 3'b000) begin
            errors++;
            $display("FAIL reset_sync: got %b expected 000",
                     {post_frame_vsync, post_frame_href, post_frame_clken});
        end
        checks++;
        if ({post_img_red, post_img_green, post_img_blue} !== 24'd0) begin
            errors++;
            $display("FAIL reset_rgb: got %h expected 000000",
                     {post_img_red, post_img_green, post_img_blue});
        end
`ifdef VIP_YCBCR_SAT_CNT_EN
        checks++;
        if (sat_count !== '0) begin
            errors++;
            $display("FAIL reset_sat_count: got %0d expected 0", sat_count);
        end
`endif
        rst_n = 1'b1;
        flush();
    endtask

    // One pixel, then check exact 3-clk latency and the returned RGB
    task automatic test_single_pixel(input string name, input logic [7:0] y, input logic [7:0] cb,
                                     input logic [7:0] cr, input logic [7:0] er,
                                     input logic [7:0] eg, input logic [7:0] eb);
        flush();
        drive(1'b0, 1'b1, 1'b1, y, cb, cr);
        tick();
        idle();
        tick();
        checks++;
        if (post_frame_clken !== 1'b0 || post_frame_href !== 1'b0) begin
            errors++;
            $display("FAIL %s_early: clken/href got %b%b expected 00 at 2 clk",
                     name, post_frame_clken, post_frame_href);
        end
        tick();
        checks++;
        if (post_frame_clken !== 1'b1 || post_frame_href !== 1'b1) begin
            errors++;
            $display("FAIL %s_latency: clken/href got %b%b expected 11 at 3 clk",
                     name, post_frame_clken, post_frame_href);
        end
        checks++;
        if (post_img_red !== er || post_img_green !== eg || post_img_blue !== eb) begin
            errors++;
            $display("FAIL %s_rgb: got %0d/%0d/%0d expected %0d/%0d/%0d", name,
                     post_img_red, post_img_green, post_img_blue, er, eg, eb);
        end
        tick();
        checks++;
        if (post_frame_clken !== 1'b0 || {post_img_red, post_img_green, post_img_blue} !== 24'd0) begin
            errors++;
            $display("FAIL %s_after: clken %b rgb %h expected 0 and 000000",
                     name, post_frame_clken, {post_img_red, post_img_green, post_img_blue});
        end
    endtask

    task automatic test_grey;
        test_single_pixel("grey", 8'd128, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128);
    endtask

    task automatic test_top_clamp;
        test_single_pixel("top_clamp", 8'd255, 8'd128, 8'd255, 8'd255, 8'd164, 8'd255);
    endtask

    task automatic test_bottom_clamp;
        test_single_pixel("bottom_clamp", 8'd0, 8'd0, 8'd0, 8'd0, 8'd136, 8'd0);
    endtask

    task automatic test_sync_alignment;
        flush();
        for (int i = 0; i < 12; i++) begin
            if (i < 10)
                drive(1'(sa_v[i]), 1'(sa_h[i]), 1'(sa_c[i]), 8'(sa_y[i]), 8'd128, 8'd128);
            else
                idle();
            tick();
            if (i >= 2) begin
                checks++;
                if (post_frame_vsync !== 1'(sa_v[i-2]) || post_frame_href !== 1'(sa_h[i-2]) ||
                    post_frame_clken !== 1'(sa_c[i-2])) begin
                    errors++;
                    $display("FAIL sync_slot%0d: vhc got %b%b%b expected %0d%0d%0d", i - 2,
                             post_frame_vsync, post_frame_href, post_frame_clken,
                             sa_v[i-2], sa_h[i-2], sa_c[i-2]);
                end
                checks++;
                if (post_img_red !== 8'(sa_e[i-2]) || post_img_green !== 8'(sa_e[i-2]) ||
                    post_img_blue !== 8'(sa_e[i-2])) begin
                    errors++;
                    $display("FAIL sync_rgb%0d: got %0d/%0d/%0d expected %0d", i - 2,
                             post_img_red, post_img_green, post_img_blue, sa_e[i-2]);
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        flush();
        for (int i = 0; i < 6; i++) begin
            if (i < 4)
                drive(1'b0, 1'b1, 1'b1, 8'(bb_y[i]), 8'(bb_cb[i]), 8'(bb_cr[i]));
            else
                idle();
            tick();
            if (i >= 2) begin
                checks++;
                if (post_frame_href !== 1'b1 || post_img_red !== 8'(bb_r[i-2]) ||
                    post_img_green !== 8'(bb_g[i-2]) || post_img_blue !== 8'(bb_b[i-2])) begin
                    errors++;
                    $display("FAIL b2b_pix%0d: href %b rgb %0d/%0d/%0d expected 1 %0d/%0d/%0d",
                             i - 2, post_frame_href, post_img_red, post_img_green, post_img_blue,
                             bb_r[i-2], bb_g[i-2], bb_b[i-2]);
                end
            end
        end
    endtask

    task automatic test_mid_frame_reset;
        int ey;
        flush();
        for (int i = 0; i < 10; i++) begin
            rst_n = (i == 5) ? 1'b0 : 1'b1;
            drive(1'b0, 1'b1, 1'b1, 8'(50 + i * 10), 8'd128, 8'd128);
            tick();
            ey = 50 + (i - 2) * 10;
            if ((i >= 2 && i < 5) || i >= 8) begin
                checks++;
                if (post_frame_href !== 1'b1 || post_img_red !== 8'(ey) || post_img_blue !== 8'(ey)) begin
                    errors++;
                    $display("FAIL rst_stream%0d: href %b red %0d blue %0d expected 1 %0d %0d",
                             i, post_frame_href, post_img_red, post_img_blue, ey, ey);
                end
            end else if (i >= 5 && i <= 7) begin
                checks++;
                if ({post_frame_vsync, post_frame_href, post_frame_clken} !== 3'b000 ||
                    {post_img_red, post_img_green, post_img_blue} !== 24'd0) begin
                    errors++;
                    $display("FAIL rst_flush%0d: vhc %b rgb %h expected 000 000000", i,
                             {post_frame_vsync, post_frame_href, post_frame_clken},
                             {post_img_red, post_img_green, post_img_blue});
                end
            end
        end
        rst_n = 1'b1;
        flush();
    endtask

`ifdef VIP_YCBCR_SAT_CNT_EN
    // Frame of n_black clamping pixels and n_grey neutral pixels, closed by a vsync pulse
    task automatic sat_frame(input string name, input int n_black, input int n_grey,
                             input logic [TB_SAT_W-1:0] expected);
        for (int i = 0; i < n_black; i++) begin
            drive(1'b0, 1'b1, 1'b1, 8'd0, 8'd0, 8'd0);
            tick();
        end
        for (int i = 0; i < n_grey; i++) begin
            drive(1'b0, 1'b1, 1'b1, 8'd128, 8'd128, 8'd128);
            tick();
        end
        flush();
        drive(1'b1, 1'b0, 1'b0, 8'd0, 8'd128, 8'd128);
        tick();
        idle();
        repeat (3) tick();
        checks++;
        if (sat_count !== expected) begin
            errors++;
            $display("FAIL %s: sat_count got %0d expected %0d", name, sat_count, expected);
        end
        flush();
    endtask

    task automatic test_sat_count;
        flush();
        drive(1'b1, 1'b0, 1'b0, 8'd0, 8'd128, 8'd128);
        tick();
        flush();
        sat_frame("sat_three", 3, 3, TB_SAT_W'(3));
        sat_frame("sat_zero", 0, 6, TB_SAT_W'(0));
        sat_frame("sat_saturate", (1 << TB_SAT_W) + 5, 0, '1);
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_grey();
        test_top_clamp();
        test_bottom_clamp();
        test_sync_alignment();
        test_back_to_back();
        test_mid_frame_reset();
`ifdef VIP_YCBCR_SAT_CNT_EN
        test_sat_count();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
